fft_radix4_unloader: RTL and testbench

FFT_RADIX4_UNLOADER -- requirements
Module: fft_radix4_unloader

---
 rtl/fft_radix4_pkg.sv | 28 ++
 rtl/fft_radix4_unloader_if.sv | 40 ++++
 rtl/fft_radix4_unloader.sv | 136 +++++++++++++
 tb/tb_fft_radix4_unloader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_radix4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_radix4_pkg
//  Purpose  : Shared constants, state encoding and index helper for the
//             16-point radix-4 FFT result unloader.
//  Contents : N_POINTS, IDX_W, LAST_IDX, state_t (IDLE/STREAM), digit_rev4()
//  Revision : 1.0  initial release
// ============================================================================
package fft_radix4_pkg;

    localparam int N_POINTS = 16;
    localparam int IDX_W    = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Base-4 digit reversal of a two-digit bin index: swaps the low and high
    // radix-4 digits, mapping natural bin order onto the core's output layout.
    function automatic logic [IDX_W-1:0] digit_rev4(input logic [IDX_W-1:0] k);
        return {k[1:0], k[3:2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_radix4_unloader_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft_radix4_unloader_if
//  Purpose  : Frame-capture and beat-stream bundle for the FFT unloader.
//  Ports    : frame_valid/frame_ready/frame_real/frame_imag  (frame side)
//             out_valid/out_ready/out_real/out_imag/out_index/out_last
//             overrun (sticky status)
//  Modports : master - the unloader itself
//             slave  - the surrounding system (FFT core + downstream sink)
//  Revision : 1.0  initial release
// ============================================================================
interface fft_radix4_unloader_if #(
    parameter int WIDTH = 16
);
    logic                 frame_valid;
    logic [WIDTH*16-1:0]  frame_real;
    logic [WIDTH*16-1:0]  frame_imag;
    logic                 frame_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_real;
    logic [WIDTH-1:0]     out_imag;
    logic [3:0]           out_index;
    logic                 out_last;
    logic                 overrun;

    modport master (
        input  frame_valid, frame_real, frame_imag, out_ready,
        output frame_ready, out_valid, out_real, out_imag, out_index,
               out_last, overrun
    );

    modport slave (
        output frame_valid, frame_real, frame_imag, out_ready,
        input  frame_ready, out_valid, out_real, out_imag, out_index,
               out_last, overrun
    );

endinterface
`default_nettype wire

// File: rtl/fft_radix4_unloader.sv
`default_nettype none
// ============================================================================
//  Module   : fft_radix4_unloader
//  Purpose  : Captures a 16-point FFT result frame into an internal buffer and
//             streams it out one bin per valid/ready beat.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - fft_radix4_unloader_if.master (frame in, beats out,
//                    sticky overrun flag)
//  Config   : FFT_UNLOAD_REORDER_EN defined   -> beat k reads slot digit_rev4(k)
//             FFT_UNLOAD_REORDER_EN undefined -> beat k reads slot k
//  Note     : WIDTH must match the WIDTH of the connected interface instance.
//  Revision : 1.0  initial release
// ============================================================================
module fft_radix4_unloader
    import fft_radix4_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    fft_radix4_unloader_if.master   bus
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q,   cnt_d;
    logic               overrun_q, overrun_d;

    logic [WIDTH-1:0]   buf_re_q [N_POINTS];
    logic [WIDTH-1:0]   buf_im_q [N_POINTS];

    logic               w_last;
    logic               w_frame_ready;
    logic               w_capture;
    logic               w_accept;
    logic [IDX_W-1:0]   w_src;

    assign w_last        = (state_q == STREAM) && (cnt_q == LAST_IDX);
    // Ready during the final handshake as well as IDLE so a new frame can
    // follow the previous one with no bubble.
    assign w_frame_ready = (state_q == IDLE) || (w_last && bus.out_ready);
    assign w_capture     = bus.frame_valid && w_frame_ready;
    assign w_accept      = (state_q == STREAM) && bus.out_ready;

`ifdef FFT_UNLOAD_REORDER_EN
    assign w_src = digit_rev4(cnt_q);
`else
    assign w_src = cnt_q;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    // Frame buffer: no reset, written only on a capture.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int s = 0; s < N_POINTS; s++) begin
                buf_re_q[s] <= bus.frame_real[s*WIDTH +: WIDTH];
                buf_im_q[s] <= bus.frame_imag[s*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;

        if (bus.frame_valid && !w_frame_ready) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (w_capture) begin
                    state_d = STREAM;
                    cnt_d   = '0;
                end
            end
            STREAM: begin
                if (w_capture) begin
                    // Only reachable on the last-beat handshake: restart.
                    state_d = STREAM;
                    cnt_d   = '0;
                end else if (w_accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (w_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: data is forced to zero outside STREAM so the reset
    // values hold combinationally as soon as the state clears.
    // ------------------------------------------------------------------
    always_comb begin
        bus.frame_ready = w_frame_ready;
        bus.overrun     = overrun_q;
        bus.out_valid   = 1'b0;
        bus.out_last    = 1'b0;
        bus.out_index   = '0;
        bus.out_real    = '0;
        bus.out_imag    = '0;
        if (state_q == STREAM) begin
            bus.out_valid = 1'b1;
            bus.out_last  = w_last;
            bus.out_index = cnt_q;
            bus.out_real  = buf_re_q[w_src];
            bus.out_imag  = buf_im_q[w_src];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_radix4_unloader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_radix4_unloader
//  Purpose  : Directed self-checking bench for fft_radix4_unloader; expected
//             beat order follows FFT_UNLOAD_REORDER_EN like the design build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_radix4_unloader;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_radix4_unloader_if #(.WIDTH(W)) bus ();

    fft_radix4_unloader #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [W-1:0] fr [16];
    logic signed [W-1:0] fi [16];

    // Slot read by beat k, straight from the bin-ordering definition.
    function automatic int src_of(input int k);
`ifdef FFT_UNLOAD_REORDER_EN
        return (k % 4) * 4 + (k / 4);
`else
        return k;
`endif
    endfunction

    task automatic set_ramp(input int mul);
        for (int s = 0; s < 16; s++) begin
            fr[s] = W'(s * mul);
            fi[s] = W'(-s);
        end
    endtask

    task automatic set_const(input int v);
        for (int s = 0; s < 16; s++) begin
            fr[s] = W'(v);
            fi[s] = '0;
        end
    endtask

    task automatic drive_frame();
        for (int s = 0; s < 16; s++) begin
            bus.frame_real[s*W +: W] = fr[s];
            bus.frame_imag[s*W +: W] = fi[s];
        end
        bus.frame_valid = 1'b1;
    endtask

    // Entered at posedge+1; leaves at posedge+1 with beat 0 presented.
    task automatic load_frame(input string tag);
        drive_frame();
        n_tests++;
        if (bus.frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_frame_ready: got %b want 1", tag, bus.frame_ready);
        end
        @(posedge clk); #1;
        bus.frame_valid = 1'b0;
    endtask

    task automatic check_beat(input string tag, input int k);
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_index !== 4'(k) ||
            bus.out_real !== fr[src_of(k)] || bus.out_imag !== fi[src_of(k)] ||
            bus.out_last !== (k == 15)) begin
            n_fail++;
            $display("FAIL %s_beat%0d: got v=%b idx=%0d re=%0d im=%0d last=%b want v=1 idx=%0d re=%0d im=%0d last=%b",
                     tag, k, bus.out_valid, bus.out_index, $signed(bus.out_real),
                     $signed(bus.out_imag), bus.out_last, k, fr[src_of(k)],
                     fi[src_of(k)], (k == 15));
        end
    endtask

    task automatic check_idle(input string tag);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle: got v=%b rdy=%b want v=0 rdy=1",
                     tag, bus.out_valid, bus.frame_ready);
        end
    endtask

    task automatic stream_all(input string tag);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check_beat(tag, k);
            @(posedge clk); #1;
        end
        check_idle(tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.frame_valid = 1'b0;
        bus.frame_real  = '0;
        bus.frame_imag  = '0;
        bus.out_ready   = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_index !== 4'd0 ||
            bus.out_real !== '0 || bus.out_imag !== '0 || bus.overrun !== 1'b0 ||
            bus.frame_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b last=%b idx=%0d re=%0d im=%0d ovr=%b rdy=%b want 0,0,0,0,0,0,1",
                     bus.out_valid, bus.out_last, bus.out_index, bus.out_real,
                     bus.out_imag, bus.overrun, bus.frame_ready);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle("post_reset");
    endtask

    task automatic test_stream();
        set_ramp(100);
        load_frame("stream");
        stream_all("stream");
        @(posedge clk); #1;
        check_idle("stream_stay");
    endtask

    task automatic test_stall();
        int acc = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [W-1:0] s_re, s_im;
        logic [3:0]   s_idx;
        logic         s_last;
        set_ramp(100);
        load_frame("stall");
        while (acc < 16 && cyc < 200) begin
            bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (stalled) begin
                n_tests++;
                if (bus.out_valid !== 1'b1 || bus.out_real !== s_re || bus.out_imag !== s_im ||
                    bus.out_index !== s_idx || bus.out_last !== s_last) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b idx=%0d re=%0d want v=1 idx=%0d re=%0d",
                             bus.out_valid, bus.out_index, bus.out_real, s_idx, s_re);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                check_beat("stall", acc);
                acc++;
                stalled = 1'b0;
            end else begin
                stalled = (bus.out_valid === 1'b1);
                s_re = bus.out_real; s_im = bus.out_imag;
                s_idx = bus.out_index; s_last = bus.out_last;
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++;
        if (acc != 16) begin
            n_fail++;
            $display("FAIL stall_count: got %0d accepted beats want 16", acc);
        end
        check_idle("stall_end");
    endtask

    task automatic test_back_to_back();
        set_ramp(100);
        load_frame("b2b_a");
        bus.out_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            check_beat("b2b_a", k);
            @(posedge clk); #1;
        end
        check_beat("b2b_a", 15);
        set_const(7);
        load_frame("b2b_b");
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_index !== 4'd0 || bus.out_real !== 16'd7 ||
            bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: got v=%b idx=%0d re=%0d ovr=%b want v=1 idx=0 re=7 ovr=0",
                     bus.out_valid, bus.out_index, bus.out_real, bus.overrun);
        end
        stream_all("b2b_b");
    endtask

    task automatic test_overrun();
        set_ramp(100);
        load_frame("ovr");
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check_beat("ovr", k);
            if (k == 5) begin
                for (int s = 0; s < 16; s++) begin
                    bus.frame_real[s*W +: W] = 16'h1234;
                    bus.frame_imag[s*W +: W] = 16'h4321;
                end
                bus.frame_valid = 1'b1;
            end else begin
                bus.frame_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        check_idle("ovr_end");
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1;
        n_tests++;
        if (bus.overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: got %b want 1", bus.overrun);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b want 0", bus.overrun);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        set_ramp(100);
        load_frame("mrst");
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
        end
        check_beat("mrst", 8);
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.frame_ready !== 1'b1 || bus.out_index !== 4'd0 ||
            bus.out_real !== '0) begin
            n_fail++;
            $display("FAIL mrst_async: got v=%b rdy=%b idx=%0d re=%0d want v=0 rdy=1 idx=0 re=0",
                     bus.out_valid, bus.frame_ready, bus.out_index, bus.out_real);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle("mrst_release");
        set_ramp(3);
        load_frame("mrst_new");
        stream_all("mrst_new");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_overrun();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
